dir_cmd_queue: RTL and testbench

Sits between the PS/2 receiver and the game FSM. It parses raw set-2 scancode bytes, including the E0 extended prefix and the F0 break prefix, into direction commands. Commands that are repeats or 180-degree reversals are rejected. Accepted commands are buffered in a small FIFO and released one per snake update. This lets a fast key sequence (e.g. up then left within one frame) be honoured instead of lost.

---
 rtl/dir_cmd_queue_if.sv | 23 ++
 rtl/dir_cmd_queue.sv | 112 +++++++++++
 tb/tb_dir_cmd_queue.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dir_cmd_queue_if.sv
// Bundle between the PS/2 byte source / game FSM and the direction command queue.
// The queue itself connects through the slave modport; the driver side uses master.
interface dir_cmd_queue_if #(
    parameter int DEPTH = 4
) ();
    logic [7:0]             scancode;
    logic                   scancode_valid;
    logic                   pop;
    logic                   clear;
    logic [1:0]             direction;
    logic [$clog2(DEPTH):0] queue_count;
    logic                   overflow;

    modport master (
        output scancode, scancode_valid, pop, clear,
        input  direction, queue_count, overflow
    );

    modport slave (
        input  scancode, scancode_valid, pop, clear,
        output direction, queue_count, overflow
    );
endinterface

// File: rtl/dir_cmd_queue.sv
// Set-2 scancode parser feeding a filtered FIFO of snake direction commands.
// Define DIR_WASD_EN to also accept non-extended W/A/S/D; default is arrow keys only.
module dir_cmd_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic          clk,
    input  logic          rstn,
    dir_cmd_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t           state, state_nxt;
    logic             cand_vld;
    logic [1:0]       cand;
    logic [1:0]       fifo [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, tail_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       dir_q, ref_dir;
    logic             ovf_q;
    logic             accept, do_pop, do_push, ovf_now;

    always_comb begin
        state_nxt = state;
        cand_vld  = 1'b0;
        cand      = 2'b00;
        if (bus.scancode_valid) begin
            case (state)
                S_IDLE: begin
                    case (bus.scancode)
                        8'hE0: state_nxt = S_EXT;
                        8'hF0: state_nxt = S_BRK;
`ifdef DIR_WASD_EN
                        8'h1D: begin cand_vld = 1'b1; cand = 2'b00; end
                        8'h1B: begin cand_vld = 1'b1; cand = 2'b01; end
                        8'h1C: begin cand_vld = 1'b1; cand = 2'b10; end
                        8'h23: begin cand_vld = 1'b1; cand = 2'b11; end
`else
`endif
                        default: state_nxt = S_IDLE;
                    endcase
                end
                S_EXT: begin
                    state_nxt = S_IDLE;
                    case (bus.scancode)
                        8'hF0: state_nxt = S_EXT_BRK;
                        8'hE0: state_nxt = S_EXT;
                        8'h75: begin cand_vld = 1'b1; cand = 2'b00; end
                        8'h72: begin cand_vld = 1'b1; cand = 2'b01; end
                        8'h6B: begin cand_vld = 1'b1; cand = 2'b10; end
                        8'h74: begin cand_vld = 1'b1; cand = 2'b11; end
                        default: state_nxt = S_IDLE;
                    endcase
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Filter against the newest pending command so fast sequences chain correctly;
    // the reference is sampled before any same-cycle pop.
    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign ref_dir  = (count != '0) ? fifo[tail_ptr] : dir_q;
    assign accept   = cand_vld && (cand != ref_dir) && (cand != (ref_dir ^ 2'b01));
    assign do_pop   = bus.pop && (count != '0) && !bus.clear;
    assign do_push  = accept && ((count != FULL_CNT) || do_pop) && !bus.clear;
    assign ovf_now  = accept && (count == FULL_CNT) && !do_pop && !bus.clear;

    always_ff @(posedge clk) begin
        if (do_push)
            fifo[wr_ptr] <= cand;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dir_q  <= INIT_DIR;
            ovf_q  <= 1'b0;
        end else if (bus.clear) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dir_q  <= INIT_DIR;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            ovf_q <= ovf_now;
            if (do_pop) begin
                dir_q  <= fifo[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (do_pop && !do_push)
                count <= count - CNT_W'(1);
        end
    end

    assign bus.direction   = dir_q;
    assign bus.queue_count = count;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_dir_cmd_queue.sv
// Directed bench for dir_cmd_queue with a reference FIFO scoreboard of accepted commands.
// Honours DIR_WASD_EN the same way as the design.
module tb_dir_cmd_queue;
    localparam int         DEPTH    = 4;
    localparam logic [1:0] INIT_DIR = 2'b11;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    dir_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

    dir_cmd_queue #(.DEPTH(DEPTH), .INIT_DIR(INIT_DIR)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  model_dir  = INIT_DIR;
`ifdef DIR_WASD_EN
    localparam bit WASD = 1'b1;
`else
    localparam bit WASD = 1'b0;
`endif

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, then update the scoreboard and compare all outputs.
    task automatic step(input logic [7:0] b, input bit v, input bit p, input bit clr,
                        input bit has_cand, input logic [1:0] cand, input string tag);
        logic [1:0] r;
        bit acc     = 1'b0;
        bit exp_ovf = 1'b0;
        bus.scancode       = b;
        bus.scancode_valid = v;
        bus.pop            = p;
        bus.clear          = clr;
        @(posedge clk);
        #1;
        bus.scancode_valid = 1'b0;
        bus.pop            = 1'b0;
        bus.clear          = 1'b0;
        if (clr) begin
            exp_q.delete();
            model_dir = INIT_DIR;
        end else begin
            if (v && has_cand) begin
                r   = (exp_q.size() > 0) ? exp_q[$] : model_dir;
                acc = (cand != r) && (cand != (r ^ 2'b01));
            end
            if (p && exp_q.size() > 0)
                model_dir = exp_q.pop_front();
            if (acc) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(cand);
                else exp_ovf = 1'b1;
            end
        end
        check({tag, "_count"}, 8'(bus.queue_count), 8'(exp_q.size()));
        check({tag, "_dir"},   8'(bus.direction),   8'(model_dir));
        check({tag, "_ovf"},   8'(bus.overflow),    8'(exp_ovf));
    endtask

    task automatic arrow(input logic [7:0] code, input logic [1:0] d, input string tag);
        step(8'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, {tag, "_pfx"});
        step(code,  1'b1, 1'b0, 1'b0, 1'b1, d,     tag);
    endtask

    task automatic do_pop(input string tag);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, tag);
    endtask

    initial begin
        bus.scancode       = 8'h00;
        bus.scancode_valid = 1'b0;
        bus.pop            = 1'b0;
        bus.clear          = 1'b0;
        #12;
        check("rst_dir",   8'(bus.direction),   8'h03);
        check("rst_count", 8'(bus.queue_count), 8'h00);
        check("rst_ovf",   8'(bus.overflow),    8'h00);
        @(negedge clk);
        rstn = 1'b1;

        // Reversal and repeat against the initial right direction
        arrow(8'h6B, 2'b10, "t2_left_rev");
        arrow(8'h74, 2'b11, "t2_right_rep");
        check("t2_count", 8'(bus.queue_count), 8'h00);

        // Single command, then release on pop
        arrow(8'h75, 2'b00, "t1_up");
        check("t1_count", 8'(bus.queue_count), 8'h01);
        check("t1_dir",   8'(bus.direction),   8'h03);
        do_pop("t1_pop");
        check("t1_dir_pop", 8'(bus.direction), 8'h00);

        // Tail-based filtering: left is checked against pending up
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "t3_clr");
        arrow(8'h75, 2'b00, "t3_up");
        arrow(8'h6B, 2'b10, "t3_left");
        check("t3_count", 8'(bus.queue_count), 8'h02);
        do_pop("t3_pop1");
        do_pop("t3_pop2");
        check("t3_dir", 8'(bus.direction), 8'h02);
        do_pop("t3_pop_empty");

        // Fill to DEPTH and overflow on the fifth
        arrow(8'h75, 2'b00, "t4_a1");
        arrow(8'h6B, 2'b10, "t4_a2");
        arrow(8'h72, 2'b01, "t4_a3");
        arrow(8'h74, 2'b11, "t4_a4");
        arrow(8'h75, 2'b00, "t4_a5");
        check("t4_ovf_pulse", 8'(bus.overflow), 8'h01);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, "t4_idle");
        check("t4_count", 8'(bus.queue_count), 8'h04);
        for (int unsigned i = 0; i < 4; i++) do_pop("t4_drain");

        // Same fill, but the fifth push coincides with a pop
        arrow(8'h75, 2'b00, "t4b_a1");
        arrow(8'h6B, 2'b10, "t4b_a2");
        arrow(8'h72, 2'b01, "t4b_a3");
        arrow(8'h74, 2'b11, "t4b_a4");
        step(8'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t4b_pfx");
        step(8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, "t4b_push_pop");
        check("t4b_count", 8'(bus.queue_count), 8'h04);
        check("t4b_ovf",   8'(bus.overflow),    8'h00);
        for (int unsigned i = 0; i < 4; i++) do_pop("t4b_drain");
        check("t4b_last_dir", 8'(bus.direction), 8'h00);

        // Break sequences produce nothing and leave the parser idle
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "t5_clr");
        step(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t5_f0");
        step(8'h1D, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t5_brk_w");
        step(8'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t5_e0");
        step(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t5_e0f0");
        step(8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t5_brk_up");
        step(8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t5_bare75");
        step(8'h1D, 1'b1, 1'b0, 1'b0, WASD, 2'b00, "t5_w");
        check("t5_w_count", 8'(bus.queue_count), 8'(WASD));

        // Clear wins over simultaneous push and pop
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, "t6_clr0");
        arrow(8'h75, 2'b00, "t6_up");
        arrow(8'h6B, 2'b10, "t6_left");
        arrow(8'h72, 2'b01, "t6_down");
        check("t6_count3", 8'(bus.queue_count), 8'h03);
        step(8'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t6_pfx");
        step(8'h74, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, "t6_clear");
        check("t6_count", 8'(bus.queue_count), 8'h00);
        check("t6_dir",   8'(bus.direction),   8'h03);

        // Async reset after a prefix returns the parser to idle
        arrow(8'h75, 2'b00, "t6r_up");
        step(8'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t6r_pfx");
        #2 rstn = 1'b0;
        #1;
        check("t6r_count", 8'(bus.queue_count), 8'h00);
        check("t6r_dir",   8'(bus.direction),   8'h03);
        exp_q.delete();
        model_dir = INIT_DIR;
        @(negedge clk);
        rstn = 1'b1;
        step(8'h75, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "t6r_bare75");
        check("t6r_after", 8'(bus.queue_count), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
